// File: rtl/vg_mux_pipe.sv
// Dual-sided vector mux followed by a PIPE_DEPTH-stage stallable register pipeline.
// Optional build macro VG_MUX_PIPE_GATE_INVALID_EN zeroes data of INVALID tokens at stage-1 load.
module vg_mux_pipe #(
  parameter int unsigned DATA_WID   = 16,
  parameter int unsigned MUX_NUM    = 8,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned SEL_WID    = $clog2(NUM_IN)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_IN-1:0][MUX_NUM-1:0][DATA_WID-1:0] A,
  input  logic [NUM_IN-1:0][MUX_NUM-1:0][DATA_WID-1:0] B,
  input  logic [SEL_WID-1:0]                      sel_A,
  input  logic [SEL_WID-1:0]                      sel_B,
  input  logic                                    stall,
  input  logic [1:0]                              status_in,
  output logic [1:0]                              status_out,
  output logic [MUX_NUM-1:0][DATA_WID-1:0]        OUT_A,
  output logic [MUX_NUM-1:0][DATA_WID-1:0]        OUT_B
);

  localparam logic [1:0] StInvalid = 2'd0;

  logic [MUX_NUM-1:0][DATA_WID-1:0] sel_a;
  logic [MUX_NUM-1:0][DATA_WID-1:0] sel_b;

  logic [PIPE_DEPTH-1:0][MUX_NUM-1:0][DATA_WID-1:0] data_a_q;
  logic [PIPE_DEPTH-1:0][MUX_NUM-1:0][DATA_WID-1:0] data_b_q;
  logic [PIPE_DEPTH-1:0][1:0]                       status_q;

  // Stage 0: each side independently falls back to zero lanes on an out-of-range select.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (int'(sel_A) < int'(NUM_IN)) sel_a = A[sel_A];
    if (int'(sel_B) < int'(NUM_IN)) sel_b = B[sel_B];
`ifdef VG_MUX_PIPE_GATE_INVALID_EN
    if (status_in == StInvalid) begin
      sel_a = '0;
      sel_b = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
      for (int i = 0; i < int'(PIPE_DEPTH); i++) status_q[i] <= StInvalid;
    end else if (!stall) begin
      data_a_q[0] <= sel_a;
      data_b_q[0] <= sel_b;
      status_q[0] <= status_in;
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        data_a_q[i] <= data_a_q[i-1];
        data_b_q[i] <= data_b_q[i-1];
        status_q[i] <= status_q[i-1];
      end
    end
  end

  assign OUT_A      = data_a_q[PIPE_DEPTH-1];
  assign OUT_B      = data_b_q[PIPE_DEPTH-1];
  assign status_out = status_q[PIPE_DEPTH-1];

endmodule

// File: doc/vg_mux_pipe.md
# vg_mux_pipe

Parametrised, pipelined successor of the CNN datapath vector mux. It selects one of NUM_IN vectors on each of two independent sides, A and B. Each vector has MUX_NUM signed DATA_WID-bit lanes. The selection passes through a PIPE_DEPTH-stage register pipeline with a global stall. The PE_STATE status token travels in lock-step with the data. It sits between the PE-array operand buffers and the PE inputs, where operand sources now exceed two and timing needs extra register stages.

## Interface
- DATA_WID, 16, lane width in bits, signed
- MUX_NUM, 8, lanes per vector
- NUM_IN, 4, candidate vectors per side; legal values are 2..16
- PIPE_DEPTH, 2, register stages from input to output; legal values are 1..8
- SEL_WID, $clog2(NUM_IN), select width (derived, not overridden)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- A  in  NUM_IN x MUX_NUM x DATA_WID  side-A candidates, indexed A[i][lane]
- B  in  NUM_IN x MUX_NUM x DATA_WID  side-B candidates
- sel_A  in  SEL_WID  side-A select
- sel_B  in  SEL_WID  side-B select
- stall  in  1  when high, every pipeline stage holds its contents
- status_in  in  PE_STATE  token accompanying this cycle's operands
- status_out  out  PE_STATE  token aligned with OUT_A/OUT_B
- OUT_A  out  MUX_NUM x DATA_WID  selected side-A vector, registered
- OUT_B  out  MUX_NUM x DATA_WID  selected side-B vector, registered

## Operation
- Stage 0 is combinational: selA = A[sel_A], selB = B[sel_B].
  - If a select value is ≥ NUM_IN, that side selects all-zero lanes.
  - The out-of-range check is per side, independent of the other side.
- Stages 1..PIPE_DEPTH are registers. Each holds {data_A, data_B, status}. Stage PIPE_DEPTH drives the outputs.
- stall=0: every stage loads from the previous stage; stage 1 loads from stage 0.
- stall=1: every stage holds. Inputs presented during a stall are dropped. The upstream producer must hold its operands while stall=1.
- reset=1: all data registers clear to 0 and all status registers load INVALID.
  - reset overrides stall.
  - reset mid-stream flushes every in-flight token; nothing from before reset ever appears at the outputs.
- The status token is carried unchanged; the block never generates or alters it. FINISH and COMPL travel exactly like VALID.
- Data is carried unchanged in all status states unless VG_MUX_PIPE_GATE_INVALID_EN is defined (see Configuration).
- Sides A and B are fully independent apart from the shared stall and reset.

## Timing
- Latency is PIPE_DEPTH clock edges. Operands sampled at edge t (stall=0) appear on the outputs just after edge t+PIPE_DEPTH-1.
  - PIPE_DEPTH=1 is a single registered mux.
- Throughput: one token per cycle while stall=0.
- Stall cycles add 1:1 to the latency of every in-flight token.
- After reset deasserts, status_out stays INVALID for PIPE_DEPTH edges, or longer if stalled.
- Outputs change only on posedge clk. There is no combinational path from any input to any output.
- Output reset values: OUT_A = 0 and OUT_B = 0 in all lanes; status_out = INVALID.

## Configuration
- Macro: VG_MUX_PIPE_GATE_INVALID_EN.
- Defined: at stage-1 load, a token whose status_in is INVALID has its data forced to zero on both sides. OUT_A/OUT_B therefore read 0 whenever status_out = INVALID, which reduces downstream toggle power.
- Not defined: data passes through regardless of status. With INVALID status, OUT_A/OUT_B carry whatever was selected.
- Latency and stall behaviour are identical in both builds.

## Test plan
- Reset, select, latency: hold reset 2 cycles with status_in=VALID, then release. Use NUM_IN=4, PIPE_DEPTH=2, A[2][0]=16'h00aa, sel_A=2, B[1][7]=16'ha00a, sel_B=1, status_in=VALID. -> During reset and for 2 edges after, outputs are 0 and status_out is INVALID; 2 edges after sampling, OUT_A[0]=16'h00aa, OUT_B[7]=16'ha00a, status_out=VALID.
- Streaming: change sel_A every cycle through 0,1,2,3 with status sequence VALID, FINISH, COMPL, VALID. -> The same sequence appears at the outputs 2 cycles later, one token per cycle, with status aligned to its own data.
- Stall: assert stall for 3 cycles mid-stream. -> Outputs are frozen for those cycles. Tokens sampled before the stall resume in order with 3 extra cycles of latency. Inputs offered during the stall never appear.
- Out of range: NUM_IN=3, sel_A=3, sel_B=0, B[0][0]=16'hffaa. -> OUT_A is all zero, OUT_B[0]=16'hffaa, status passes through.
- Reset mid-stream: assert reset with 2 tokens in flight while stall=1. -> On the next edge all outputs are 0 and status_out is INVALID; no pre-reset token emerges afterwards.
- Gating: status_in=INVALID with A[0][1]=16'h1234 selected. -> With VG_MUX_PIPE_GATE_INVALID_EN, OUT_A[1]=0. Without it, OUT_A[1]=16'h1234. In both builds status_out=INVALID.
